// File: rtl/adc_frame_packer.sv
// Packs one ADC sample set per strobe into an AXI4-Stream frame: a sample-counter header word
// followed by one sign-extended word per channel. Dropped strobes are counted as overruns.
module adc_frame_packer #(
  parameter int unsigned ADC_CHANNELS   = 8,
  parameter int unsigned ADC_DATA_WIDTH = 18,
  parameter int unsigned TDATA_WIDTH    = 32,
  parameter int unsigned TCQ            = 1
) (
  input  logic                               adc_read_clk,
  input  logic                               rstn,
  input  logic                               acq_en,
  input  logic                               sample_strobe,
  input  logic [ADC_DATA_WIDTH*ADC_CHANNELS-1:0] adc_data_arr,
  output logic [TDATA_WIDTH-1:0]             m_axis_tdata,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  output logic [31:0]                        sample_cnt,
  output logic [15:0]                        overrun_cnt,
  output logic                               busy
);

  localparam int unsigned IdxW = (ADC_CHANNELS > 1) ? $clog2(ADC_CHANNELS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(ADC_CHANNELS - 1);

  if (ADC_CHANNELS < 2 || ADC_CHANNELS > 48 || (ADC_CHANNELS % 2) != 0 ||
      TDATA_WIDTH < 32 || TDATA_WIDTH < ADC_DATA_WIDTH || TCQ > 100) begin : g_bad_params
    $error("adc_frame_packer: unsupported parameter set");
  end

  typedef enum logic [1:0] {StIdle, StHeader, StData} state_e;

  state_e                    state_q, state_d;
  logic [IdxW-1:0]           ch_idx_q, ch_idx_d;
  logic [31:0]               header_q, header_d;
  logic [31:0]               sample_cnt_q, sample_cnt_d;
  logic [15:0]               overrun_cnt_q, overrun_cnt_d;
  logic                      acq_en_q;
  logic [ADC_DATA_WIDTH-1:0] snap_q [ADC_CHANNELS];

  logic                      counted;
  logic                      acq_rise;
  logic                      snap_load;
  logic [31:0]               sample_base;
  logic [15:0]               overrun_base;
  logic [ADC_DATA_WIDTH-1:0] cur_sample;

  assign counted      = sample_strobe && acq_en;
  assign acq_rise     = acq_en && !acq_en_q;
  // A fresh enable restarts both counters, even if a strobe lands in the same cycle.
  assign sample_base  = acq_rise ? 32'd0 : sample_cnt_q;
  assign overrun_base = acq_rise ? 16'd0 : overrun_cnt_q;
  assign snap_load    = counted && (state_q == StIdle);

  always_comb begin
    state_d       = state_q;
    ch_idx_d      = ch_idx_q;
    header_d      = header_q;
    sample_cnt_d  = sample_base;
    overrun_cnt_d = overrun_base;

    if (counted) begin
      sample_cnt_d = sample_base + 32'd1;
      if (state_q != StIdle) begin
        overrun_cnt_d = (overrun_base == 16'hFFFF) ? overrun_base : overrun_base + 16'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (counted) begin
          header_d = sample_base;
          state_d  = StHeader;
        end
      end
      StHeader: begin
        if (m_axis_tready) begin
          ch_idx_d = '0;
          state_d  = StData;
        end
      end
      StData: begin
        if (m_axis_tready) begin
          if (ch_idx_q == LastIdx) begin
            ch_idx_d = '0;
            state_d  = StIdle;
          end else begin
            ch_idx_d = ch_idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge adc_read_clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      ch_idx_q      <= '0;
      header_q      <= '0;
      sample_cnt_q  <= '0;
      overrun_cnt_q <= '0;
      acq_en_q      <= 1'b0;
      for (int k = 0; k < ADC_CHANNELS; k++) snap_q[k] <= '0;
    end else begin
      state_q       <= state_d;
      ch_idx_q      <= ch_idx_d;
      header_q      <= header_d;
      sample_cnt_q  <= sample_cnt_d;
      overrun_cnt_q <= overrun_cnt_d;
      acq_en_q      <= acq_en;
      if (snap_load) begin
        for (int k = 0; k < ADC_CHANNELS; k++) begin
          snap_q[k] <= adc_data_arr[ADC_DATA_WIDTH*k +: ADC_DATA_WIDTH];
        end
      end
    end
  end

  assign cur_sample = snap_q[ch_idx_q];

  // Outputs decode registered state only, so they never depend on tready and hold while stalled.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    unique case (state_q)
      StIdle: ;
      StHeader: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = TDATA_WIDTH'(header_q);
      end
      StData: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = TDATA_WIDTH'($signed(cur_sample));
        m_axis_tlast  = (ch_idx_q == LastIdx);
      end
      default: ;
    endcase
  end

  assign sample_cnt  = sample_cnt_q;
  assign overrun_cnt = overrun_cnt_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer: a per-cycle vector table for the basic frame, then
// hand-written sequences for backpressure, overrun, enable control, saturation/wrap and reset.
module tb_adc_frame_packer;

  localparam int NCH = 8;
  localparam int DW  = 18;
  localparam int TW  = 32;

  typedef logic [DW-1:0] samp_t;

  typedef struct {
    logic        acq;
    logic        stb;
    logic        rdy;
    logic        tv;
    logic        tl;
    logic        bz;
    logic [31:0] data;
    logic [31:0] scnt;
    logic [15:0] ocnt;
  } vec_t;

  logic                adc_read_clk = 1'b0;
  logic                rstn = 1'b0;
  logic                acq_en = 1'b0;
  logic                sample_strobe = 1'b0;
  logic [DW*NCH-1:0]   adc_data_arr = '0;
  logic [TW-1:0]       m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready = 1'b0;
  logic                m_axis_tlast;
  logic [31:0]         sample_cnt;
  logic [15:0]         overrun_cnt;
  logic                busy;

  int n_cmp = 0;
  int n_bad = 0;

  samp_t fa [NCH];
  samp_t fb [NCH];
  vec_t  vt [11];

  adc_frame_packer #(
    .ADC_CHANNELS   (NCH),
    .ADC_DATA_WIDTH (DW),
    .TDATA_WIDTH    (TW),
    .TCQ            (1)
  ) dut (
    .adc_read_clk  (adc_read_clk),
    .rstn          (rstn),
    .acq_en        (acq_en),
    .sample_strobe (sample_strobe),
    .adc_data_arr  (adc_data_arr),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .sample_cnt    (sample_cnt),
    .overrun_cnt   (overrun_cnt),
    .busy          (busy)
  );

  always #5 adc_read_clk = ~adc_read_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge adc_read_clk);
    #1;
  endtask

  function automatic logic [31:0] sext(input samp_t s);
    return {{(32-DW){s[DW-1]}}, s};
  endfunction

  function automatic logic [DW*NCH-1:0] pack(input samp_t d [NCH]);
    logic [DW*NCH-1:0] r;
    for (int k = 0; k < NCH; k++) r[DW*k +: DW] = d[k];
    return r;
  endfunction

  // Strobe a frame from idle; returns with the DUT in its header cycle.
  task automatic strobe_frame(input samp_t d [NCH]);
    adc_data_arr  = pack(d);
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    adc_data_arr  = '0;
  endtask

  // Consume a whole frame from its header onwards, checking every word and AXIS stability.
  task automatic drain(input string tag, input logic [31:0] hdr, input samp_t d [NCH],
                       input bit bp, input int drop_at);
    int          idx = 0;
    int          lasts = 0;
    int          cyc = 0;
    bit          stalled = 0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 0;
    logic [31:0] exp;
    while (idx < NCH + 1 && cyc < 200) begin
      chk($sformatf("%s w%0d tvalid", tag, idx), {31'd0, m_axis_tvalid}, 32'd1);
      if (!m_axis_tvalid) break;
      if (stalled) begin
        chk($sformatf("%s w%0d hold tdata", tag, idx), m_axis_tdata, prev_data);
        chk($sformatf("%s w%0d hold tlast", tag, idx), {31'd0, m_axis_tlast}, {31'd0, prev_last});
      end
      exp = (idx == 0) ? hdr : sext(d[idx-1]);
      chk($sformatf("%s w%0d tdata", tag, idx), m_axis_tdata, exp);
      chk($sformatf("%s w%0d tlast", tag, idx), {31'd0, m_axis_tlast},
          {31'd0, (idx == NCH)});
      if (idx == drop_at) acq_en = 1'b0;
      m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled   = !m_axis_tready;
      prev_data = m_axis_tdata;
      prev_last = m_axis_tlast;
      if (m_axis_tready && m_axis_tlast) lasts++;
      if (m_axis_tready) idx++;
      tick();
      cyc++;
    end
    m_axis_tready = 1'b0;
    chk({tag, " words"}, 32'(idx), 32'(NCH + 1));
    chk({tag, " tlast count"}, 32'(lasts), 32'd1);
    chk({tag, " tvalid after"}, {31'd0, m_axis_tvalid}, 32'd0);
    chk({tag, " busy after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    fa = '{18'h1FFFF, 18'h20000, 18'h3FFFF, 18'h00000, 18'h12345, 18'h2ABCD, 18'h0FFFF, 18'h00001};
    fb = '{18'h3FFFE, 18'h00100, 18'h20001, 18'h1ABCD, 18'h2FFFF, 18'h00ABC, 18'h3C000, 18'h1FFFE};

    //         acq   stb   rdy   tv    tl    bz    data           scnt   ocnt
    vt[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'd0, 16'd0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'd1, 16'd0};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0001_FFFF, 32'd1, 16'd0};
    vt[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFE_0000, 32'd1, 16'd0};
    vt[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 16'd0};
    vt[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'd1, 16'd0};
    vt[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0001_2345, 32'd1, 16'd0};
    vt[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFE_ABCD, 32'd1, 16'd0};
    vt[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_FFFF, 32'd1, 16'd0};
    vt[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0001, 32'd1, 16'd0};
    vt[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'd1, 16'd0};

    // Reset values, before any clock edge is seen.
    #1;
    chk("reset tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("reset tdata", m_axis_tdata, 32'd0);
    chk("reset tlast", {31'd0, m_axis_tlast}, 32'd0);
    chk("reset sample_cnt", sample_cnt, 32'd0);
    chk("reset overrun_cnt", {16'd0, overrun_cnt}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    @(negedge adc_read_clk);
    rstn = 1'b1;
    tick();

    // Basic frame, one vector per cycle.
    for (int i = 0; i < 11; i++) begin
      acq_en        = vt[i].acq;
      sample_strobe = vt[i].stb;
      m_axis_tready = vt[i].rdy;
      adc_data_arr  = pack(fa);
      chk($sformatf("vec%0d tvalid", i), {31'd0, m_axis_tvalid}, {31'd0, vt[i].tv});
      chk($sformatf("vec%0d tlast", i), {31'd0, m_axis_tlast}, {31'd0, vt[i].tl});
      chk($sformatf("vec%0d busy", i), {31'd0, busy}, {31'd0, vt[i].bz});
      chk($sformatf("vec%0d tdata", i), m_axis_tdata, vt[i].data);
      chk($sformatf("vec%0d sample_cnt", i), sample_cnt, vt[i].scnt);
      chk($sformatf("vec%0d overrun_cnt", i), {16'd0, overrun_cnt}, {16'd0, vt[i].ocnt});
      tick();
    end
    sample_strobe = 1'b0;
    m_axis_tready = 1'b0;

    // Random backpressure across a frame.
    strobe_frame(fb);
    drain("bp", 32'd1, fb, 1'b1, -1);
    chk("bp sample_cnt", sample_cnt, 32'd2);

    // Strobe while disabled is ignored.
    acq_en        = 1'b0;
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    tick();
    chk("dis tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("dis sample_cnt", sample_cnt, 32'd2);
    chk("dis overrun_cnt", {16'd0, overrun_cnt}, 32'd0);

    // Overrun: re-enable clears counters, second strobe 3 cycles later is dropped.
    acq_en = 1'b1;
    strobe_frame(fa);
    tick();
    tick();
    adc_data_arr  = pack(fb);
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    adc_data_arr  = '0;
    chk("ovr overrun_cnt", {16'd0, overrun_cnt}, 32'd1);
    chk("ovr sample_cnt", sample_cnt, 32'd2);
    chk("ovr header held", m_axis_tdata, 32'd0);
    drain("ovr", 32'd0, fa, 1'b0, -1);
    strobe_frame(fb);
    drain("ovr next", 32'd2, fb, 1'b0, -1);
    chk("ovr next sample_cnt", sample_cnt, 32'd3);

    // acq_en dropped mid-frame: frame completes, counters hold until re-enable.
    strobe_frame(fa);
    drain("drop", 32'd3, fa, 1'b0, 4);
    chk("drop sample_cnt", sample_cnt, 32'd4);
    chk("drop overrun_cnt", {16'd0, overrun_cnt}, 32'd1);
    acq_en = 1'b1;
    tick();
    chk("reen sample_cnt", sample_cnt, 32'd0);
    chk("reen overrun_cnt", {16'd0, overrun_cnt}, 32'd0);

    // Overrun counter saturation.
    strobe_frame(fa);
    force dut.overrun_cnt_q = 16'hFFFE;
    #1;
    release dut.overrun_cnt_q;
    chk("sat preset", {16'd0, overrun_cnt}, 32'h0000_FFFE);
    sample_strobe = 1'b1;
    tick();
    tick();
    tick();
    sample_strobe = 1'b0;
    chk("sat overrun_cnt", {16'd0, overrun_cnt}, 32'h0000_FFFF);
    chk("sat sample_cnt", sample_cnt, 32'd4);
    drain("sat", 32'd0, fa, 1'b0, -1);

    // Sample counter wrap.
    force dut.sample_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.sample_cnt_q;
    chk("wrap preset", sample_cnt, 32'hFFFF_FFFF);
    strobe_frame(fb);
    chk("wrap sample_cnt", sample_cnt, 32'd0);
    drain("wrap", 32'hFFFF_FFFF, fb, 1'b0, -1);

    // Asynchronous reset after word 4 of a frame.
    strobe_frame(fa);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    m_axis_tready = 1'b0;
    chk("rst pre busy", {31'd0, busy}, 32'd1);
    #3;
    rstn = 1'b0;
    #1;
    chk("rst tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst tlast", {31'd0, m_axis_tlast}, 32'd0);
    chk("rst tdata", m_axis_tdata, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst sample_cnt", sample_cnt, 32'd0);
    chk("rst overrun_cnt", {16'd0, overrun_cnt}, 32'd0);
    @(negedge adc_read_clk);
    rstn = 1'b1;
    tick();
    strobe_frame(fb);
    drain("post rst", 32'd0, fb, 1'b0, -1);
    chk("post rst sample_cnt", sample_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
